riscv_muldiv_unit: RTL and testbench
====================================

// Module: riscv_muldiv_unit
// PURPOSE
//  Multi-cycle RV32M/RV64M arithmetic unit; replaces the single-cycle MULH path in the core controller.
//  Accepts one operation per handshake and iterates over it.
//  Returns the XLEN-bit result with its destination register tag.
//  Sits between decode/register-read and register writeback.
// PARAMETERS
//  XLEN            32  operand/result width; legal values 32 or 64
//  BITS_PER_CYCLE  1   multiplier bits retired per CALC cycle; legal 1,2,4,8; must divide XLEN
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     operation offered
//  in_ready   out  1     unit can accept; in_ready = (state==IDLE)
//  funct3     in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx divide group
//  rs1_data   in   XLEN  operand A
//  rs2_data   in   XLEN  operand B
//  rd_in      in   5     destination tag, carried through unchanged
//  out_valid  out  1     result available; held until out_ready
//  out_ready  in   1     consumer takes result
//  result     out  XLEN  result value
//  rd_out     out  5     tag of the operation in result
//  illegal    out  1     qualifies result: unsupported funct3
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; out_valid=0, illegal=0, busy=0, result=0, rd_out=0; in_ready=1 after reset deasserts.
//  - FSM IDLE -> CALC on in_valid&&in_ready.
//    Latch funct3, rd_in and operands; signed operands are converted to magnitudes; the result-negate flag is recorded.
//  - CALC: shift-add of BITS_PER_CYCLE bits per cycle into a 2*XLEN accumulator.
//    Exactly XLEN/BITS_PER_CYCLE cycles, then -> DONE.
//  - DONE: negate if flagged, select the half, drive out_valid=1.
//    DONE -> IDLE on out_valid&&out_ready.
//  - Latency: accept at edge N; out_valid=1 after edge N+XLEN/BITS_PER_CYCLE+1.
//    For XLEN=32, BITS_PER_CYCLE=1 that is 33 cycles.
//  - Selection:
//    MUL = low XLEN bits.
//    MULH = high half, signed x signed.
//    MULHSU = high half, signed rs1 x unsigned rs2.
//    MULHU = high half, unsigned x unsigned.
//  - No accept in DONE, even when out_ready=1 in the same cycle; one operation in flight.
//  - result, rd_out and illegal are stable while out_valid=1 and out_ready=0.
//  - in_valid while busy is ignored; operands are not sampled.
//  - rd_in=0 is processed normally; writeback suppression is the consumer's job.
//  - rst_n low mid-CALC or mid-DONE: operation aborted, all outputs return to reset values, no result emitted.
//  - Operands changing after acceptance have no effect.
// CONFIGURATION
//  Macro MULDIV_DIV_EN:
//  - Defined: funct3 1xx = DIV, DIVU, REM, REMU via restoring divider, 1 bit/cycle.
//    Always XLEN CALC cycles regardless of BITS_PER_CYCLE.
//    Divide by zero: quotient = all ones, remainder = rs1.
//    Signed overflow (min_int / -1): quotient = min_int, remainder = 0.
//    REM sign follows the dividend; DIV sign is the XOR of the operand signs.
//  - Undefined: funct3 1xx goes IDLE -> DONE directly with illegal=1 and result=0.
//    out_valid=1 after edge N+1; no divider logic is synthesised.
// TESTING
//  1. MULH 0x80000000 x 0x80000000, rd=5 -> result 0x40000000, rd_out=5, out_valid at cycle 33.
//  2. MUL 7 x 0xFFFFFFFD (-3) -> 0xFFFFFFEB.
//     MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//     MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
//  3. out_ready held low 10 cycles after out_valid -> result/rd_out stable, in_ready=0, new in_valid not accepted.
//  4. rst_n pulsed low at CALC cycle 12 -> out_valid never rises; in_ready=1 next cycle; next MUL 3x4 -> 12.
//  5. MULDIV_DIV_EN:
//     DIV 0x00000014 / 0 -> 0xFFFFFFFF.
//     REM 0x80000000 / 0xFFFFFFFF -> 0.
//     DIV -7 / 2 -> 0xFFFFFFFD.
//     Undefined: any 1xx -> illegal=1, result=0 at cycle 1.
//  6. BITS_PER_CYCLE=4, XLEN=64: MULHU 0xFFFFFFFFFFFFFFFF squared -> 0xFFFFFFFFFFFFFFFE, out_valid at cycle 17.

Source files
------------

// File: rtl/riscv_muldiv_unit.sv
// rtl/riscv_muldiv_unit.sv - multi-cycle RV32M/RV64M multiply (and optional divide) unit
// Optional divider enabled by defining MULDIV_DIV_EN; otherwise funct3 1xx is flagged illegal.
module riscv_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            illegal,
  output logic            busy
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int CW  = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / BPC - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [2:0]      op;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [CW-1:0]   cnt;
  logic            neg;

  logic                  sa, sb, a_neg, b_neg, neg_in;
  logic [XLEN-1:0]       a_mag, b_mag;
  logic [XLEN+BPC-1:0]   partial, mul_sum;
  logic [2*XLEN-1:0]     prod;
  logic [XLEN-1:0]       mul_res, done_val;
  logic [CW-1:0]         calc_last;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Sign handling at acceptance: operands become magnitudes, sign of the result kept in neg
  always_comb begin
    sa     = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sb     = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg  = sa && rs1_data[XLEN-1];
    b_neg  = sb && rs2_data[XLEN-1];
    a_mag  = a_neg ? -rs1_data : rs1_data;
    b_mag  = b_neg ? -rs2_data : rs2_data;
    neg_in = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // Shift-add: multiplier sits in lo and is consumed from the bottom as product bits fill in
  always_comb begin
    partial = {{BPC{1'b0}}, mcand} * {{XLEN{1'b0}}, lo[BPC-1:0]};
    mul_sum = {{BPC{1'b0}}, hi} + partial;
    prod    = neg ? -{hi, lo} : {hi, lo};
    mul_res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_DIV_EN
  logic            div0;
  logic [XLEN:0]   rem_shift, trial;
  logic [XLEN-1:0] div_res;

  // Restoring divide: hi is the partial remainder, lo shifts dividend out and quotient in
  always_comb begin
    rem_shift = {hi, lo[XLEN-1]};
    trial     = rem_shift - {1'b0, mcand};
    if (op[1])
      div_res = neg ? -hi : hi;
    else if (div0)
      div_res = '1;
    else
      div_res = neg ? -lo : lo;
    done_val  = op[2] ? div_res : mul_res;
    calc_last = op[2] ? CW'(XLEN - 1) : MUL_LAST;
  end
`else
  always_comb begin
    done_val  = op[2] ? '0 : mul_res;
    calc_last = MUL_LAST;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= '0;
      rd_q      <= '0;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
      illegal   <= 1'b0;
`ifdef MULDIV_DIV_EN
      div0      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op    <= funct3;
            rd_q  <= rd_in;
            neg   <= neg_in;
            hi    <= '0;
            cnt   <= '0;
            state <= CALC;
`ifdef MULDIV_DIV_EN
            div0  <= (rs2_data == '0);
            if (funct3[2]) begin
              mcand <= b_mag;
              lo    <= a_mag;
            end else begin
              mcand <= a_mag;
              lo    <= b_mag;
            end
`else
            mcand <= a_mag;
            lo    <= b_mag;
            if (funct3[2]) state <= DONE;
`endif
          end
        end
        CALC: begin
`ifdef MULDIV_DIV_EN
          if (op[2]) begin
            if (!trial[XLEN]) begin
              hi <= trial[XLEN-1:0];
              lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
              hi <= rem_shift[XLEN-1:0];
              lo <= {lo[XLEN-2:0], 1'b0};
            end
          end else begin
            hi <= mul_sum[XLEN+BPC-1:BPC];
            lo <= {mul_sum[BPC-1:0], lo[XLEN-1:BPC]};
          end
`else
          hi <= mul_sum[XLEN+BPC-1:BPC];
          lo <= {mul_sum[BPC-1:0], lo[XLEN-1:BPC]};
`endif
          if (cnt == calc_last) state <= DONE;
          else                  cnt   <= cnt + 1'b1;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            result    <= done_val;
            rd_out    <= rd_q;
`ifdef MULDIV_DIV_EN
            illegal   <= 1'b0;
`else
            illegal   <= op[2];
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb/tb_riscv_muldiv_unit.sv - directed self-checking bench for riscv_muldiv_unit
// Checks 32-bit/1-bit-per-cycle and 64-bit/4-bits-per-cycle builds; divide checks follow MULDIV_DIV_EN.
module tb_riscv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, illegal, busy;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, result;
  logic [4:0]  rd_in, rd_out;

  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, illegal_w, busy_w;
  logic [2:0]  funct3_w;
  logic [63:0] rs1_w, rs2_w, result_w;
  logic [4:0]  rd_in_w, rd_out_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .rd_out(rd_out), .illegal(illegal), .busy(busy)
  );

  riscv_muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .funct3(funct3_w), .rs1_data(rs1_w), .rs2_data(rs2_w), .rd_in(rd_in_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .result(result_w),
    .rd_out(rd_out_w), .illegal(illegal_w), .busy(busy_w)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issue one op, wait for the result, optionally stall the consumer, then retire it
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input logic exp_ill,
                        input int exp_lat, input int hold);
    int cyc;
    @(negedge clk);
    funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'd31;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_result"}, 64'(result), 64'(exp_res));
    check({tag, "_rd"}, 64'(rd_out), 64'(rd));
    check({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; funct3 = 3'b000; rs1_data = 32'd2; rs2_data = 32'd2;
      @(posedge clk); #1;
      check({tag, "_hold_result"}, 64'(result), 64'(exp_res));
      check({tag, "_hold_rd"}, 64'(rd_out), 64'(rd));
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_retired_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_retired_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; rd_in = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b0; funct3_w = '0; rs1_w = '0; rs2_w = '0; rd_in_w = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_rd_out", 64'(rd_out), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    run_op("mulh_min_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, 1'b0, 33, 0);
    run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 1'b0, 33, 0);
    run_op("mulhu_ones", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b0, 33, 0);
    run_op("mulhsu_ones", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 1'b0, 33, 0);
    run_op("mul_rd0", 3'b000, 32'h0001_0000, 32'h0001_0003, 5'd0, 32'h0003_0000, 1'b0, 33, 0);
    run_op("stall_mul", 3'b000, 32'd5, 32'd6, 5'd9, 32'd30, 1'b0, 33, 10);

    // Abort mid-calculation with an asynchronous reset pulse
    @(negedge clk);
    funct3 = 3'b000; rs1_data = 32'd100; rs2_data = 32'd100; rd_in = 5'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    run_op("after_abort_mul", 3'b000, 32'd3, 32'd4, 5'd6, 32'd12, 1'b0, 33, 0);

`ifdef MULDIV_DIV_EN
    run_op("div_by_zero", 3'b100, 32'h0000_0014, 32'd0, 5'd10, 32'hFFFF_FFFF, 1'b0, 33, 0);
    run_op("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1'b0, 33, 0);
    run_op("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b0, 33, 0);
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFD, 1'b0, 33, 0);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFF, 1'b0, 33, 0);
    run_op("remu_by_zero", 3'b111, 32'h1234_5678, 32'd0, 5'd15, 32'h1234_5678, 1'b0, 33, 0);
`else
    run_op("illegal_100", 3'b100, 32'h0000_0014, 32'd3, 5'd10, 32'd0, 1'b1, 1, 0);
    run_op("illegal_111", 3'b111, 32'hFFFF_FFFF, 32'd7, 5'd11, 32'd0, 1'b1, 1, 0);
`endif

    // 64-bit build retiring 4 multiplier bits per cycle
    @(negedge clk);
    funct3_w = 3'b011; rs1_w = '1; rs2_w = '1; rd_in_w = 5'd7; in_valid_w = 1'b1;
    @(posedge clk); #1;
    in_valid_w = 1'b0; rs1_w = '0; rs2_w = '0;
    cyc = 0;
    while (!out_valid_w && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w64_mulhu_latency", 64'(cyc), 64'd17);
    check("w64_mulhu_result", result_w, 64'hFFFF_FFFF_FFFF_FFFE);
    check("w64_mulhu_rd", 64'(rd_out_w), 64'd7);
    out_ready_w = 1'b1;
    @(posedge clk); #1;
    out_ready_w = 1'b0;
    check("w64_retired_busy", 64'(busy_w), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
